// File: rtl/lbm_pkg.sv
// Shared D2Q9 definitions for the population store: lattice directions,
// velocity offsets, opposite-direction mapping and the sweep FSM states.
package lbm_pkg;

  localparam int Q = 9;

  typedef enum logic [3:0] {
    DIR_REST = 4'd0,
    DIR_N    = 4'd1,
    DIR_NE   = 4'd2,
    DIR_E    = 4'd3,
    DIR_SE   = 4'd4,
    DIR_S    = 4'd5,
    DIR_SW   = 4'd6,
    DIR_W    = 4'd7,
    DIR_NW   = 4'd8
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_PRESENT = 3'd2,
    ST_WB      = 3'd3,
    ST_BOUNCE  = 3'd4,
    ST_SWAP    = 3'd5
  } state_e;

  function automatic logic signed [1:0] dir_cx(input dir_e d);
    case (d)
      DIR_NE, DIR_E, DIR_SE: dir_cx = 2'sb01;
      DIR_SW, DIR_W, DIR_NW: dir_cx = 2'sb11;
      default:               dir_cx = 2'sb00;
    endcase
  endfunction

  function automatic logic signed [1:0] dir_cy(input dir_e d);
    case (d)
      DIR_N, DIR_NE, DIR_NW: dir_cy = 2'sb01;
      DIR_SE, DIR_S, DIR_SW: dir_cy = 2'sb11;
      default:               dir_cy = 2'sb00;
    endcase
  endfunction

  function automatic dir_e dir_opp(input dir_e d);
    logic [3:0] v;
    if (d == DIR_REST) begin
      v = 4'd0;
    end else begin
      v = ((4'(d) + 4'd3) % 4'd8) + 4'd1;
    end
    return dir_e'(v);
  endfunction

endpackage

// File: rtl/lbm_dp_ram.sv
// Simple dual-port population RAM: one write and one registered read per cycle.
// The bank bit is the address MSB, so depth is 2*NX*NY for power-of-two grids.
module lbm_dp_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [2**AW];

  // Storage write and registered read; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/lbm_population_store.sv
// D2Q9 population store and streaming engine: raster sweep over ping-pong banks,
// valid/ready hand-off to collision, streamed write-back with wrap or bounce-back.
module lbm_population_store
  import lbm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NX         = 16,
  parameter int NY         = 16,
  parameter int CELL_AW    = $clog2(NX*NY)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    bc_mode,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             step_count,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [CELL_AW-1:0]      rd_x,
  output logic [CELL_AW-1:0]      rd_y,
  output logic [Q*DATA_WIDTH-1:0] rd_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [Q*DATA_WIDTH-1:0] wr_data,
  input  logic                    host_we,
  input  logic [CELL_AW-1:0]      host_addr,
  input  logic [Q*DATA_WIDTH-1:0] host_wdata,
  output logic [Q*DATA_WIDTH-1:0] host_rdata
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = Q*DATA_WIDTH;
  localparam logic [CELL_AW-1:0] ZERO_C = {CELL_AW{1'b0}};
  localparam logic [CELL_AW-1:0] ONE_C  = {{(CELL_AW-1){1'b0}}, 1'b1};
  localparam logic [CELL_AW-1:0] X_MAX  = CELL_AW'(NX-1);
  localparam logic [CELL_AW-1:0] Y_MAX  = CELL_AW'(NY-1);
  localparam logic [CELL_AW-1:0] NX_C   = CELL_AW'(NX);

  state_e               state_r;
  logic                 cur_bank_r;
  logic                 bc_mode_r;
  logic [CELL_AW-1:0]   x_r;
  logic [CELL_AW-1:0]   y_r;
  logic [Q-1:0]         defer_mask_r;
  logic [PW-1:0]        bounce_data_r;
  logic [Q-1:0]         defer_s;
  logic [PW-1:0]        ram_q_s;
  logic [CELL_AW-1:0]   cell_s;
  logic [CELL_AW:0]     raddr_s;
  logic                 last_cell_s;
  logic                 cell_done_s;

  assign cell_s      = y_r * NX_C + x_r;
  assign last_cell_s = (x_r == X_MAX) && (y_r == Y_MAX);
  assign cell_done_s = ((state_r == ST_WB) && wr_valid && (defer_s == {Q{1'b0}}))
                     || (state_r == ST_BOUNCE);

  // Read port follows the sweep cell while busy, otherwise serves host reads.
  always_comb begin
    raddr_s = {cur_bank_r, host_addr};
    case (state_r)
      ST_READ, ST_PRESENT, ST_WB, ST_BOUNCE: raddr_s = {cur_bank_r, cell_s};
      default:                               raddr_s = {cur_bank_r, host_addr};
    endcase
  end

  assign rd_data    = ram_q_s;
  assign host_rdata = ram_q_s;

  for (genvar k = 0; k < Q; k++) begin : g_ch
    localparam logic signed [1:0] CX = dir_cx(dir_e'(k));
    localparam logic signed [1:0] CY = dir_cy(dir_e'(k));
    localparam int OPP_I = int'(dir_opp(dir_e'(k)));

    logic [CELL_AW-1:0] dx_s;
    logic [CELL_AW-1:0] dy_s;
    logic               out_x_s;
    logic               out_y_s;
    logic [CELL_AW-1:0] dst_s;
    logic               we_s;
    logic [CELL_AW:0]   waddr_s;
    logic [DW-1:0]      wdata_s;

    // Streaming destination of this channel, wrapping and flagging grid exits.
    always_comb begin
      dx_s    = x_r;
      dy_s    = y_r;
      out_x_s = 1'b0;
      out_y_s = 1'b0;
      if (CX == 2'sb01) begin
        if (x_r == X_MAX) begin dx_s = ZERO_C; out_x_s = 1'b1; end
        else begin dx_s = x_r + ONE_C; end
      end else if (CX == 2'sb11) begin
        if (x_r == ZERO_C) begin dx_s = X_MAX; out_x_s = 1'b1; end
        else begin dx_s = x_r - ONE_C; end
      end else begin
        dx_s = x_r;
      end
      if (CY == 2'sb01) begin
        if (y_r == Y_MAX) begin dy_s = ZERO_C; out_y_s = 1'b1; end
        else begin dy_s = y_r + ONE_C; end
      end else if (CY == 2'sb11) begin
        if (y_r == ZERO_C) begin dy_s = Y_MAX; out_y_s = 1'b1; end
        else begin dy_s = y_r - ONE_C; end
      end else begin
        dy_s = y_r;
      end
    end

    assign dst_s      = dy_s * NX_C + dx_s;
    assign defer_s[k] = bc_mode_r && (out_x_s || out_y_s);

    // Write port: host load in IDLE, streamed write in WB, reflected write in BOUNCE.
    always_comb begin
      we_s    = 1'b0;
      waddr_s = {(CELL_AW+1){1'b0}};
      wdata_s = {DW{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (host_we) begin
            we_s    = 1'b1;
            waddr_s = {cur_bank_r, host_addr};
            wdata_s = host_wdata[k*DW +: DW];
          end else begin
            we_s = 1'b0;
          end
        end
        ST_WB: begin
          if (wr_valid && !defer_s[k]) begin
            we_s    = 1'b1;
            waddr_s = {~cur_bank_r, dst_s};
            wdata_s = wr_data[k*DW +: DW];
          end else begin
            we_s = 1'b0;
          end
        end
        ST_BOUNCE: begin
          if (defer_mask_r[OPP_I]) begin
            we_s    = 1'b1;
            waddr_s = {~cur_bank_r, cell_s};
            wdata_s = bounce_data_r[OPP_I*DW +: DW];
          end else begin
            we_s = 1'b0;
          end
        end
        default: we_s = 1'b0;
      endcase
    end

    lbm_dp_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .AW        (CELL_AW+1)
    ) u_ram (
      .clk  (clk),
      .we   (we_s),
      .waddr(waddr_s),
      .wdata(wdata_s),
      .raddr(raddr_s),
      .rdata(ram_q_s[k*DW +: DW])
    );
  end

  // Sweep FSM with registered handshake/status outputs and cell counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_valid      <= 1'b0;
      wr_ready      <= 1'b0;
      step_count    <= 16'd0;
      cur_bank_r    <= 1'b0;
      bc_mode_r     <= 1'b0;
      x_r           <= ZERO_C;
      y_r           <= ZERO_C;
      rd_x          <= ZERO_C;
      rd_y          <= ZERO_C;
      defer_mask_r  <= {Q{1'b0}};
      bounce_data_r <= {PW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r   <= ST_READ;
            busy      <= 1'b1;
            bc_mode_r <= bc_mode;
            x_r       <= ZERO_C;
            y_r       <= ZERO_C;
          end
        end
        ST_READ: begin
          state_r  <= ST_PRESENT;
          rd_valid <= 1'b1;
          rd_x     <= x_r;
          rd_y     <= y_r;
        end
        ST_PRESENT: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            wr_ready <= 1'b1;
            state_r  <= ST_WB;
          end
        end
        ST_WB: begin
          if (wr_valid) begin
            wr_ready      <= 1'b0;
            defer_mask_r  <= defer_s;
            bounce_data_r <= wr_data;
            if (defer_s != {Q{1'b0}}) state_r <= ST_BOUNCE;
            else if (last_cell_s)     state_r <= ST_SWAP;
            else                      state_r <= ST_READ;
          end
        end
        ST_BOUNCE: state_r <= last_cell_s ? ST_SWAP : ST_READ;
        ST_SWAP: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
      // The bank swap lands together with done so SWAP already shows the new state.
      if (cell_done_s) begin
        if (last_cell_s) begin
          busy       <= 1'b0;
          done       <= 1'b1;
          cur_bank_r <= ~cur_bank_r;
          step_count <= step_count + 16'd1;
        end else if (x_r == X_MAX) begin
          x_r <= ZERO_C;
          y_r <= y_r + ONE_C;
        end else begin
          x_r <= x_r + ONE_C;
        end
      end
    end
  end

endmodule

// File: tb/tb_lbm_population_store.sv
// Randomised bench for lbm_population_store on a 4x4 grid, checked against a
// grid-level streaming model (whole-array update per timestep).
module tb_lbm_population_store;

  localparam int DW  = 16;
  localparam int NX  = 4;
  localparam int NY  = 4;
  localparam int NC  = NX*NY;
  localparam int CAW = $clog2(NC);
  localparam int Q   = 9;
  localparam int PW  = Q*DW;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           bc_mode = 1'b0;
  logic           rd_ready = 1'b0;
  logic           wr_valid = 1'b0;
  logic           host_we = 1'b0;
  logic [PW-1:0]  wr_data = '0;
  logic [PW-1:0]  host_wdata = '0;
  logic [CAW-1:0] host_addr = '0;
  logic           busy, done, rd_valid, wr_ready;
  logic [15:0]    step_count;
  logic [CAW-1:0] rd_x, rd_y;
  logic [PW-1:0]  rd_data, host_rdata;

  always #5 clk = ~clk;

  lbm_population_store #(.DATA_WIDTH(DW), .NX(NX), .NY(NY)) dut (
    .clk(clk), .rst(rst), .start(start), .bc_mode(bc_mode),
    .busy(busy), .done(done), .step_count(step_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata)
  );

  // Lattice tables written out by hand (N is +y, E is +x).
  int CX  [Q] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
  int CY  [Q] = '{0, 1, 1, 0, -1, -1, -1, 0, 1};
  int OPP [Q] = '{0, 5, 6, 7, 8, 1, 2, 3, 4};

  logic [DW-1:0] f [NC][Q];
  logic [DW-1:0] g [NC][Q];
  logic [15:0]   model_steps = 16'd0;
  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [PW-1:0] pack_cell(input int c);
    logic [PW-1:0] v;
    for (int k = 0; k < Q; k++) v[k*DW +: DW] = f[c][k];
    return v;
  endfunction

  function automatic logic [DW-1:0] coll(input logic [DW-1:0] v, input int k, input logic [DW-1:0] key);
    return v + DW'(int'(key) * (k + 1));
  endfunction

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm, input int waited);
    n_fail++;
    $display("FAIL %s: no response after %0d cycles, required within bound", nm, waited);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "bounded wait expired");
  endtask

  // One timestep of the reference: every population moves to its neighbour.
  task automatic model_step(input bit bcm, input logic [DW-1:0] key);
    int x, y, nx, ny;
    for (int c = 0; c < NC; c++) begin
      x = c % NX; y = c / NX;
      for (int k = 0; k < Q; k++) begin
        nx = x + CX[k]; ny = y + CY[k];
        if (nx >= 0 && nx < NX && ny >= 0 && ny < NY) g[ny*NX+nx][k] = coll(f[c][k], k, key);
        else if (bcm) g[c][OPP[k]] = coll(f[c][k], k, key);
        else g[((ny+NY)%NY)*NX + (nx+NX)%NX][k] = coll(f[c][k], k, key);
      end
    end
    f = g;
    model_steps++;
  endtask

  task automatic host_wr(input int c, input logic [PW-1:0] d);
    host_we = 1'b1; host_addr = CAW'(c); host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    for (int k = 0; k < Q; k++) f[c][k] = d[k*DW +: DW];
  endtask

  function automatic logic [PW-1:0] rand_cell();
    logic [PW-1:0] v;
    for (int k = 0; k < Q; k++) v[k*DW +: DW] = DW'($urandom());
    return v;
  endfunction

  task automatic load_grid(input bit rnd, input int only_c, input logic [PW-1:0] d);
    for (int c = 0; c < NC; c++)
      host_wr(c, (c == only_c) ? d : (rnd ? rand_cell() : '0));
  endtask

  task automatic readback(input string nm);
    for (int c = 0; c < NC; c++) begin
      host_addr = CAW'(c);
      @(negedge clk);
      chk(nm, host_rdata, pack_cell(c));
    end
  endtask

  task automatic lit(input string nm, input int x, input int y, input int k, input logic [DW-1:0] e);
    int c;
    c = y*NX + x;
    chk({nm, "_model"}, PW'(f[c][k]), PW'(e));
    host_addr = CAW'(c);
    @(negedge clk);
    chk(nm, PW'(host_rdata[k*DW +: DW]), PW'(e));
  endtask

  function automatic bit on_wall(input int c);
    return (c % NX == 0) || (c % NX == NX-1) || (c / NX == 0) || (c / NX == NY-1);
  endfunction

  task automatic sweep(input bit bcm, input logic [DW-1:0] key, input int stall_cell,
                       input int rd_stall, input int wr_delay, input bit noise,
                       input int abort_cell, output bit aborted);
    int waits, base;
    logic [PW-1:0] wd;
    aborted = 1'b0;
    base = done_cnt;
    start = 1'b1; bc_mode = bcm;
    @(negedge clk);
    start = 1'b0; bc_mode = ~bcm;
    chk("busy_after_start", PW'(busy), PW'(1'b1));
    for (int c = 0; c < NC; c++) begin
      waits = 0;
      while (rd_valid !== 1'b1 && waits < 8) begin @(negedge clk); waits++; end
      if (rd_valid !== 1'b1) timeout("rd_valid", waits);
      chk("cell_gap", PW'(waits), PW'((c > 0 && bcm && on_wall(c-1)) ? 2 : 1));
      chk("rd_x", PW'(rd_x), PW'(c % NX));
      chk("rd_y", PW'(rd_y), PW'(c / NX));
      chk("rd_data", rd_data, pack_cell(c));
      if (c == abort_cell) begin
        rst = 1'b0;
        #1;
        chk("abort_busy", PW'(busy), '0);
        chk("abort_rd_valid", PW'(rd_valid), '0);
        chk("abort_wr_ready", PW'(wr_ready), '0);
        chk("abort_done", PW'(done), '0);
        chk("abort_step", PW'(step_count), '0);
        chk("abort_xy", PW'({rd_x, rd_y}), '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_steps = 16'd0;
        @(negedge clk);
        aborted = 1'b1;
        return;
      end
      if (c == stall_cell) begin
        repeat (rd_stall) begin
          if (noise) begin
            start = 1'b1; host_we = 1'b1; host_addr = CAW'($urandom()); host_wdata = rand_cell();
          end
          @(negedge clk);
          start = 1'b0; host_we = 1'b0;
          chk("stall_rd_valid", PW'(rd_valid), PW'(1'b1));
          chk("stall_rd_data", rd_data, pack_cell(c));
          chk("stall_xy", PW'({rd_x, rd_y}), PW'({CAW'(c % NX), CAW'(c / NX)}));
        end
      end
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      chk("wr_ready", PW'(wr_ready), PW'(1'b1));
      chk("rd_valid_drop", PW'(rd_valid), '0);
      if (c == stall_cell) begin
        repeat (wr_delay) begin
          @(negedge clk);
          chk("wr_ready_hold", PW'(wr_ready), PW'(1'b1));
        end
      end
      for (int k = 0; k < Q; k++) wd[k*DW +: DW] = coll(f[c][k], k, key);
      wr_data = wd; wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
      chk("wr_ready_drop", PW'(wr_ready), '0);
    end
    waits = 0;
    while (done !== 1'b1 && waits < 4) begin @(negedge clk); waits++; end
    if (done !== 1'b1) timeout("done", waits);
    chk("done_gap", PW'(waits), PW'(bcm ? 1 : 0));
    chk("busy_at_done", PW'(busy), '0);
    model_step(bcm, key);
    chk("step_count", PW'(step_count), PW'(model_steps));
    @(negedge clk);
    chk("done_pulse_width", PW'(done), '0);
    chk("done_count", PW'(done_cnt - base), PW'(1));
  endtask

  logic [PW-1:0] pat;
  bit ab;
  int base0;

  initial begin
    for (int k = 0; k < Q; k++) pat[k*DW +: DW] = DW'(k + 1);
    repeat (3) @(negedge clk);
    chk("rst_busy", PW'(busy), '0);
    chk("rst_done", PW'(done), '0);
    chk("rst_rd_valid", PW'(rd_valid), '0);
    chk("rst_wr_ready", PW'(wr_ready), '0);
    chk("rst_step", PW'(step_count), '0);
    chk("rst_xy", PW'({rd_x, rd_y}), '0);
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of a sweep leaves the loaded bank untouched.
    load_grid(1'b1, -1, '0);
    sweep(1'b0, 16'd0, -1, 0, 0, 1'b0, 5, ab);
    chk("abort_taken", PW'(ab), PW'(1'b1));
    chk("abort_step_after", PW'(step_count), '0);
    readback("abort_rb");

    // Periodic identity step from a single loaded cell.
    load_grid(1'b0, 0, pat);
    sweep(1'b0, 16'd0, -1, 0, 0, 1'b0, -1, ab);
    readback("per_rb");
    lit("per_E", 1, 0, 3, 16'd4);
    lit("per_N", 0, 1, 1, 16'd2);
    lit("per_S", 0, 3, 5, 16'd6);
    lit("per_SW", 3, 3, 6, 16'd7);
    lit("per_rest", 0, 0, 0, 16'd1);
    chk("per_step", PW'(step_count), PW'(16'd1));

    // Bounce-back at the corner cell.
    load_grid(1'b0, 0, pat);
    sweep(1'b1, 16'd0, -1, 0, 0, 1'b0, -1, ab);
    readback("bb_rb");
    lit("bb_N", 0, 0, 1, 16'd6);
    lit("bb_E", 0, 0, 3, 16'd8);
    lit("bb_NE", 0, 0, 2, 16'd7);
    lit("bb_SE", 0, 0, 4, 16'd9);
    lit("bb_NW", 0, 0, 8, 16'd5);
    lit("bb_rest", 0, 0, 0, 16'd1);
    lit("bb_E10", 1, 0, 3, 16'd4);
    lit("bb_N01", 0, 1, 1, 16'd2);
    lit("bb_NE11", 1, 1, 2, 16'd3);

    // Backpressure on cell 5 must not change the result.
    load_grid(1'b0, 0, pat);
    sweep(1'b0, 16'd0, 5, 5, 3, 1'b0, -1, ab);
    readback("bp_rb");
    lit("bp_E", 1, 0, 3, 16'd4);
    lit("bp_SW", 3, 3, 6, 16'd7);

    // Four periodic sweeps bring an east-mover around the 4-wide grid.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_steps = 16'd0;
    @(negedge clk);
    load_grid(1'b0, 0, PW'(16'd1) << (3*DW));
    base0 = done_cnt;
    repeat (4) sweep(1'b0, 16'd0, -1, 0, 0, 1'b0, -1, ab);
    lit("wrap_E", 0, 0, 3, 16'd1);
    readback("wrap_rb");
    chk("wrap_step", PW'(step_count), PW'(16'd4));
    chk("wrap_dones", PW'(done_cnt - base0), PW'(4));

    // Random grids, modes, collision keys, stalls and ignored host/start noise.
    for (int i = 0; i < 4; i++) begin
      load_grid(1'b1, -1, '0);
      sweep(1'($urandom()), DW'($urandom()), int'($urandom_range(0, NC-1)),
            int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'b1, -1, ab);
      readback("rand_rb");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
